pwm_drive_sequencer: RTL

Parametrised two-motor H-bridge drive engine for the robot's drive path. It sits between the navigation/junction logic and the H-bridge pins. It accepts drive commands over a valid/ready handshake: per-motor duty in percent, direction, and optional duration. It generates the PWM enables from a single shared period counter, with:
- duty slew limiting,
- safe ramp-down/dead-time on direction reversal,
- timed manoeuvres,
- an emergency-stop override.

---
 rtl/pwm_drive_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pwm_drive_sequencer.sv
// pwm_drive_sequencer: two-motor H-bridge PWM engine with slew limiting, reversal dead-time, timed moves and e-stop
//   clk, rst_n          system clock, asynchronous active-low reset
//   cmdValid/cmdReady   command handshake; cmdDutyA/B percent, cmdDirA/B (1 = forward), cmdPeriods (0 = hold)
//   estop               level-sensitive emergency stop
//   hbEnA/B             PWM enables; hbIn1/hbIn2 motor A pins, hbIn3/hbIn4 motor B pins
//   busy, cmdDone       timed command in progress / one-cycle expiry pulse
module pwm_drive_sequencer #(
    parameter int CLK_HZ           = 50_000_000,
    parameter int PWM_HZ           = 80,
    parameter int MAX_DUTY_PCT     = 80,
    parameter int RAMP_STEP        = 10,
    parameter int DEADTIME_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [6:0]  cmdDutyA,
    input  logic [6:0]  cmdDutyB,
    input  logic        cmdDirA,
    input  logic        cmdDirB,
    input  logic [15:0] cmdPeriods,
    input  logic        estop,
    output logic        hbEnA,
    output logic        hbEnB,
    output logic        hbIn1,
    output logic        hbIn2,
    output logic        hbIn3,
    output logic        hbIn4,
    output logic        busy,
    output logic        cmdDone
);
    localparam int PERIOD = CLK_HZ / PWM_HZ;
    localparam int STEP   = PERIOD / 100;
    localparam int CW     = $clog2(PERIOD);
    localparam logic [6:0] MAX_DUTY = 7'(MAX_DUTY_PCT);
    localparam logic [6:0] RAMP     = RAMP_STEP >= 100 ? 7'd127 : 7'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, HOLD, ACTIVE} topState_t;
    typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD} motorState_t;

    topState_t       topState, topNext;
    logic [CW-1:0]   count;
    logic [15:0]     perCnt, perLen;
    logic            live, boundary, accept, expire;
    logic [1:0][6:0] cmdDuty;
    logic [1:0]      cmdDir, en, fwd, rev;

    // one slew step toward goal, never overshooting
    function automatic logic [6:0] rampTo(input logic [6:0] cur, input logic [6:0] goal);
        return cur < goal ? (goal - cur > RAMP ? cur + RAMP : goal)
                          : (cur - goal > RAMP ? cur - RAMP : goal);
    endfunction

    assign cmdDuty  = {cmdDutyB, cmdDutyA};
    assign cmdDir   = {cmdDirB, cmdDirA};
    assign boundary = count == CW'(PERIOD - 1);
    assign accept   = cmdValid && cmdReady;
    assign expire   = !estop && topState == ACTIVE && boundary && perCnt + 16'd1 == perLen;

    // live drops the cycle after estop (and stays low through reset) to gate the bridge pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            live    <= 1'b0;
            perCnt  <= '0;
            perLen  <= '0;
            cmdDone <= 1'b0;
        end else begin
            count   <= boundary ? '0 : count + 1'b1;
            live    <= !estop;
            perCnt  <= accept ? '0 : topState == ACTIVE && boundary ? perCnt + 16'd1 : perCnt;
            perLen  <= accept ? cmdPeriods : perLen;
            cmdDone <= expire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) topState <= IDLE;
        else topState <= topNext;
    end

    always_comb begin
        topNext = topState;
        if (estop) topNext = IDLE;
        else if (accept) topNext = cmdPeriods == 16'd0 ? HOLD : ACTIVE;
        else if (expire) topNext = IDLE;
    end

    always_comb begin
        cmdReady = live && !estop && topState != ACTIVE;
        busy     = topState == ACTIVE;
    end

    for (genvar g = 0; g < 2; g++) begin : motor
        motorState_t state, stateNext;
        logic [6:0]  curDuty, tgt, nextDuty, eff;
        logic [15:0] deadCnt;
        logic        dir, pendDir, deadDone, reverse, enQ, drvFwd, drvRev;

        assign eff      = cmdDuty[g] > MAX_DUTY ? MAX_DUTY : cmdDuty[g];
        assign reverse  = cmdDir[g] != dir;
        assign deadDone = 32'(deadCnt) + 32'd1 >= 32'(DEADTIME_PERIODS);
        // internal target is 0 while reversing; the boundary that ends dead-time already ramps up
        assign nextDuty = rampTo(curDuty, (state == RUN || (state == DEAD && deadDone)) ? tgt : 7'd0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state <= RUN;
            else state <= stateNext;
        end

        always_comb begin
            stateNext = state;
            if (estop) stateNext = RUN;
            else if (accept && state == RUN) stateNext = reverse && curDuty != 7'd0 ? RAMP_DOWN : RUN;
            else if (accept && !reverse) stateNext = RUN;
            else if (boundary && state == RAMP_DOWN && nextDuty == 7'd0) stateNext = DEAD;
            else if (boundary && state == DEAD && deadDone) stateNext = RUN;
        end

        always_comb begin
            drvFwd = live && state != DEAD && dir;
            drvRev = live && state != DEAD && !dir;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                curDuty <= '0;
                tgt     <= '0;
                dir     <= 1'b1;
                pendDir <= 1'b1;
                deadCnt <= '0;
                enQ     <= 1'b0;
            end else if (estop) begin
                curDuty <= '0;
                tgt     <= '0;
                deadCnt <= '0;
                enQ     <= 1'b0;
            end else begin
                curDuty <= boundary ? nextDuty : curDuty;
                tgt     <= accept ? eff : expire ? 7'd0 : tgt;
                pendDir <= accept ? cmdDir[g] : pendDir;
                // direction changes on an idle-motor reversal, or when leaving RAMP_DOWN/DEAD for RUN
                if (state == RUN ? accept && reverse && curDuty == 7'd0 : stateNext == RUN)
                    dir <= accept ? cmdDir[g] : pendDir;
                deadCnt <= state != DEAD ? '0 : boundary ? deadCnt + 16'd1 : deadCnt;
                enQ     <= 32'(count) < 32'(STEP) * 32'(curDuty);
            end
        end

        assign en[g]  = enQ;
        assign fwd[g] = drvFwd;
        assign rev[g] = drvRev;
    end

    assign hbEnA = en[0];
    assign hbEnB = en[1];
    assign hbIn1 = rev[0];
    assign hbIn2 = fwd[0];
    assign hbIn3 = fwd[1];
    assign hbIn4 = rev[1];
endmodule
